// File: rtl/if_prefetch_buf.sv
// Instruction-fetch prefetch buffer.
// Issues sequential fetches to inst_sram, keeps the pc of each accepted
// request in an in-order tag queue, and queues responses in a small
// buffer whose head feeds decode. A redirect restarts the stream; responses
// still owed for the old stream are discarded through cancel_cnt.
// Optional build macro IF_BUF_BYPASS_EN: when the buffer is empty, a live
// response is presented to decode in the same cycle and, if accepted,
// never written into the buffer.
module if_prefetch_buf #(
  parameter int          OUTSTANDING = 2,
  parameter int          BUF_DEPTH   = 4,
  parameter logic [31:0] RESET_PC    = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int AW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int DEPTH2 = 1 << AW;
  // wide enough to hold OUTSTANDING + BUF_DEPTH without wrapping
  localparam int CW     = $clog2(BUF_DEPTH + OUTSTANDING + 1) + 1;

  logic [31:0]   fetch_pc_reg;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] cancel_cnt_reg;
  logic [CW-1:0] count_reg;
  logic          halt_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] tq_rd_reg;
  logic [AW-1:0] tq_wr_reg;
  logic [64:0]   buf_mem [DEPTH2];
  logic [31:0]   tag_mem [DEPTH2];

  logic          issue;
  logic          resp_any;
  logic          resp_cancel;
  logic          resp_accept;
  logic          head_valid;
  logic          byp_valid;
  logic          byp_take;
  logic          push;
  logic          pop;
  logic          misaligned;
  logic          adel_wr;
  logic [64:0]   resp_entry;
  logic [DEPTH2-1:0] buf_we;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // Request gating: credit on both the memory side and the buffer side
  assign inst_sram_req  = ~reset & ~redirect & ~halt_reg
                        & ((inflight_reg + cancel_cnt_reg) < CW'(OUTSTANDING))
                        & ((inflight_reg + count_reg) < CW'(BUF_DEPTH));
  assign inst_sram_addr = fetch_pc_reg;
  assign issue          = inst_sram_req & inst_sram_addr_ok;

  // A response with nothing owed is ignored entirely
  assign resp_any    = inst_sram_data_ok & ((cancel_cnt_reg != '0) | (inflight_reg != '0));
  assign resp_cancel = inst_sram_data_ok & (cancel_cnt_reg != '0);
  assign resp_accept = ~reset & ~redirect & inst_sram_data_ok
                     & (cancel_cnt_reg == '0) & (inflight_reg != '0);
  assign resp_entry  = {1'b0, inst_sram_rdata, tag_mem[tq_rd_reg]};

  assign head_valid = ~reset & (count_reg != '0);
`ifdef IF_BUF_BYPASS_EN
  assign byp_valid = resp_accept & (count_reg == '0);
`else
  assign byp_valid = 1'b0;
`endif
  assign byp_take = byp_valid & ds_allowin;
  assign pop      = head_valid & ds_allowin;
  assign push     = resp_accept & ~byp_take;
  assign adel_wr  = ~reset & redirect & misaligned;

  assign fs_to_ds_valid = head_valid | byp_valid;
  assign fs_to_ds_bus   = head_valid ? buf_mem[rd_ptr_reg]
                        : (byp_valid ? resp_entry : 65'd0);

  // Per-entry write enables: normal push at the tail, or the AdEL entry at slot 0
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH2; gi++) begin : g_we
      assign buf_we[gi] = (push & (wr_ptr_reg == AW'(gi))) | (adel_wr & (gi == 0));
    end
  endgenerate

  // Buffer payload storage (no reset needed; validity lives in count_reg)
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH2; i++) begin
      if (buf_we[i]) begin
        buf_mem[i] <= adel_wr ? {1'b1, 32'h0, redirect_pc} : resp_entry;
      end
    end
  end

  // Tag queue: pc of every accepted request, in issue order
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tq_wr_reg] <= fetch_pc_reg;
    end
  end

  // Fetch pointer, credit counters and queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg   <= RESET_PC;
      inflight_reg   <= '0;
      cancel_cnt_reg <= '0;
      count_reg      <= '0;
      halt_reg       <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      tq_rd_reg      <= '0;
      tq_wr_reg      <= '0;
    end else if (redirect) begin
      // Everything in flight becomes owed-but-unwanted, minus what lands now
      fetch_pc_reg   <= redirect_pc;
      halt_reg       <= misaligned;
      inflight_reg   <= '0;
      cancel_cnt_reg <= cancel_cnt_reg + inflight_reg - CW'(resp_any);
      tq_rd_reg      <= '0;
      tq_wr_reg      <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= misaligned ? AW'(1) : '0;
      count_reg      <= misaligned ? CW'(1) : '0;
    end else begin
      if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
        tq_wr_reg    <= tq_wr_reg + AW'(1);
      end
      if (resp_accept) begin
        tq_rd_reg <= tq_rd_reg + AW'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      inflight_reg   <= inflight_reg + CW'(issue) - CW'(resp_accept);
      cancel_cnt_reg <= cancel_cnt_reg - CW'(resp_cancel);
      count_reg      <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf. A small memory model answers each
// accepted request with rdata = ~addr, one cycle later unless held off.
module tb_if_prefetch_buf;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

`ifdef IF_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic        hold;
  logic [31:0] pend[$];
  logic [64:0] got[$];
  int          got_cyc[$];
  int          issue_cnt = 0;
  int          cyc = 0;

  if_prefetch_buf dut (
    .clk              (clk),
    .reset            (reset),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Memory model: in-order responses, one cycle after acceptance
  initial begin
    logic        rst_s;
    logic        iss;
    logic [31:0] a;
    logic [31:0] t;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      rst_s = reset;
      iss   = inst_sram_req & inst_sram_addr_ok;
      a     = inst_sram_addr;
      @(posedge clk);
      #2;
      if (rst_s) begin
        pend.delete();
        inst_sram_data_ok = 1'b0;
      end else begin
        if (iss) pend.push_back(a);
        if (!hold && pend.size() > 0) begin
          t = pend.pop_front();
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = ~t;
        end else begin
          inst_sram_data_ok = 1'b0;
        end
      end
    end
  end

  // Monitor: deliveries to decode and accepted requests
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && fs_to_ds_valid && ds_allowin) begin
        got.push_back(fs_to_ds_bus);
        got_cyc.push_back(cyc);
      end
      if (inst_sram_req && inst_sram_addr_ok) issue_cnt++;
    end
  end

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (got.size() < n) check(tag, 65'(got.size()), 65'(n));
  endtask

  task automatic do_reset(input logic allow, input logic hld);
    @(posedge clk);
    #1;
    reset = 1'b1; redirect = 1'b0; ds_allowin = allow;
    inst_sram_addr_ok = 1'b1; hold = hld;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int b;
    int ib;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    ds_allowin = 1'b1; inst_sram_addr_ok = 1'b1; hold = 1'b0;

    // Reset state and first fetch after release, continuous stream
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   65'(inst_sram_req), 65'd0);
    check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    check("rst_bus",   fs_to_ds_bus, 65'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rel_req",  65'(inst_sram_req), 65'd1);
    check("rel_addr", 65'(inst_sram_addr), 65'h0bfc00000);
    b = got.size();
    wait_got(b + 8, "stream_timeout");
    check("stream_e0",  got[b],            {1'b0, 32'h403fffff, 32'hbfc00000});
    check("stream_pc1", 65'(got[b+1][31:0]), 65'h0bfc00004);
    check("stream_pc2", 65'(got[b+2][31:0]), 65'h0bfc00008);
    check("stream_gap", 65'(got_cyc[b+7] - got_cyc[b]), 65'd7);

    // Decode stalled: credit limits issue to BUF_DEPTH, nothing lost
    do_reset(1'b0, 1'b0);
    ib = issue_cnt;
    b  = got.size();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("full_issues", 65'(issue_cnt - ib), 65'd4);
    check("full_req",    65'(inst_sram_req), 65'd0);
    check("full_head",   fs_to_ds_bus, {1'b0, 32'h403fffff, 32'hbfc00000});
    @(posedge clk);
    #1;
    ds_allowin = 1'b1;
    wait_got(b + 5, "full_timeout");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_pc%0d", i), 65'(got[b+i][31:0]), 65'(32'hbfc00000 + 32'(4 * i)));
    end

    // Two in flight, redirect: both old responses discarded
    do_reset(1'b1, 1'b1);
    ib = issue_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("redir_inflight", 65'(issue_cnt - ib), 65'd2);
    b = got.size();
    redirect = 1'b1; redirect_pc = 32'h80001000;
    @(posedge clk);
    #1;
    redirect = 1'b0; hold = 1'b0;
    wait_got(b + 2, "redir_timeout");
    check("redir_first", got[b], {1'b0, 32'h7fffefff, 32'h80001000});
    check("redir_next",  65'(got[b+1][31:0]), 65'h080001004);

    // Redirect and data_ok in the same cycle with one request in flight
    do_reset(1'b1, 1'b1);
    @(posedge clk);
    #1;
    inst_sram_addr_ok = 1'b0; hold = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h80002000;
    b = got.size();
    @(posedge clk);
    #1;
    redirect = 1'b0; inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    check("same_valid", 65'(fs_to_ds_valid), 65'd0);
    check("same_req",   65'(inst_sram_req), 65'd1);
    check("same_addr",  65'(inst_sram_addr), 65'h080002000);
    wait_got(b + 1, "same_timeout");
    check("same_first", got[b], {1'b0, 32'h7fffdfff, 32'h80002000});

    // Misaligned redirect: one AdEL entry, fetch halted until next redirect
    @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h80000002;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    b  = got.size();
    ib = issue_cnt;
    @(negedge clk);
    check("adel_req",   65'(inst_sram_req), 65'd0);
    check("adel_valid", 65'(fs_to_ds_valid), 65'd1);
    repeat (8) @(posedge clk);
    #1;
    check("adel_noissue", 65'(issue_cnt - ib), 65'd0);
    check("adel_count",   65'(got.size() - b), 65'd1);
    check("adel_entry",   got[b], {1'b1, 32'h0, 32'h80000002});
    check("adel_hold",    65'(inst_sram_req), 65'd0);
    redirect = 1'b1; redirect_pc = 32'h80000004;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("adel_resume_req",  65'(inst_sram_req), 65'd1);
    check("adel_resume_addr", 65'(inst_sram_addr), 65'h080000004);

    // data_ok into an empty buffer: same-cycle valid only with bypass
    do_reset(1'b1, 1'b1);
    @(posedge clk);
    #1;
    inst_sram_addr_ok = 1'b0; hold = 1'b0;
    @(negedge clk);
    check("lat_valid0", 65'(fs_to_ds_valid), 65'(BYP));
    check("lat_bus0",   fs_to_ds_bus, BYP ? {1'b0, 32'h403fffff, 32'hbfc00000} : 65'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_valid1", 65'(fs_to_ds_valid), 65'(!BYP));
    check("lat_bus1",   fs_to_ds_bus, BYP ? 65'd0 : {1'b0, 32'h403fffff, 32'hbfc00000});

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
IF_PREFETCH_BUF -- requirements
Module: if_prefetch_buf

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2: max inst_sram requests accepted but not yet answered (1..4).
REQ-002 SHALL have parameter BUF_DEPTH, default 4: fetch buffer entries (power of 2, >= OUTSTANDING).
REQ-003 SHALL have parameter RESET_PC, default 32'hbfc00000: first fetch address after reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port redirect  input  1  one-cycle pulse; discards the fetch stream and restarts it at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  32  new fetch address.
REQ-008 SHALL have port ds_allowin  input  1  decode accepts an entry this cycle.
REQ-009 SHALL have port fs_to_ds_valid  output  1  buffer head valid.
REQ-010 SHALL have port fs_to_ds_bus  output  65  {ex[64], inst[63:32], pc[31:0]} of the buffer head.
REQ-011 SHALL have port inst_sram_req  output  1  fetch request.
REQ-012 SHALL have port inst_sram_addr  output  32  request address, always the current fetch_pc.
REQ-013 SHALL have port inst_sram_addr_ok  input  1  request accepted.
REQ-014 SHALL have port inst_sram_data_ok  input  1  in-order response valid.
REQ-015 SHALL have port inst_sram_rdata  input  32  response instruction.

Function
REQ-016 SHALL track inflight (accepted, unanswered, uncancelled requests), cancel_cnt (responses still to discard) and count (buffer occupancy).
REQ-017 SHALL assert inst_sram_req iff ~reset & ~redirect & ~halt & (inflight+cancel_cnt < OUTSTANDING) & (inflight+count < BUF_DEPTH).
REQ-018 SHALL treat req & addr_ok as an issue: fetch_pc += 4 (32-bit wrap), pc pushed to an in-order tag queue, inflight +1.
REQ-019 SHALL handle data_ok with cancel_cnt>0 by decrementing cancel_cnt and discarding rdata; otherwise it pops the tag queue and pushes {0, rdata, tag} into the buffer, inflight -1.
REQ-020 SHALL pop the buffer head when fs_to_ds_valid & ds_allowin; fs_to_ds_valid = (count != 0), a registered head with no combinational path from inst_sram_* to outputs (except under REQ-030).
REQ-021 SHALL handle a simultaneous push and pop in one cycle by leaving count unchanged; a pop from a full buffer together with a push is legal.
REQ-022 SHALL, on redirect: fetch_pc <= redirect_pc; clear the buffer and tag queue; cancel_cnt <= cancel_cnt + inflight - (data_ok this cycle); inflight <= 0; discard a data_ok arriving in the same cycle.
REQ-023 SHALL, when redirect_pc[1:0] != 0, set halt, issue no requests, and push one entry {1, 32'h0, redirect_pc} (AdEL) in the next cycle; halt clears only on the next redirect.
REQ-024 SHALL not double-count a redirect coinciding with an issue, since the request is suppressed that cycle (REQ-017).
REQ-025 SHALL never let inflight+cancel_cnt exceed OUTSTANDING, nor inflight+count exceed BUF_DEPTH; a data_ok with inflight=cancel_cnt=0 is illegal and ignored.

Reset
REQ-026 SHALL, while reset is high: inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_bus=0, inflight=cancel_cnt=count=0, halt=0, fetch_pc=RESET_PC.
REQ-027 SHALL let reset mid-operation drop all in-flight state with no cancel accounting kept; the memory side is reset concurrently.
REQ-028 SHALL assert inst_sram_req with addr RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL use macro IF_BUF_BYPASS_EN to compile the bypass path in or out.
REQ-030 SHALL, with IF_BUF_BYPASS_EN defined: when count=0 and an uncancelled data_ok occurs, present {0, rdata, tag} combinationally on the outputs the same cycle; if ds_allowin, it is consumed without a buffer write.
REQ-031 SHALL, without IF_BUF_BYPASS_EN: every response is written to the buffer first, giving a minimum data_ok-to-valid latency of 1 cycle.

Verification
REQ-032 SHALL cover: reset release, addr_ok always 1, data_ok 1 cycle later, ds_allowin=1 -> pcs bfc00000, bfc00004, bfc00008 delivered in order, no gaps after fill.
REQ-033 SHALL cover: ds_allowin=0, OUTSTANDING=2, BUF_DEPTH=4 -> exactly 4 issues, then req=0; count=4; no entry lost after ds_allowin=1.
REQ-034 SHALL cover: 2 requests in flight, redirect to 0x80001000 -> next 2 data_ok discarded; first delivered entry has pc 0x80001000.
REQ-035 SHALL cover: redirect and data_ok in the same cycle with inflight=1 -> response dropped, cancel_cnt=0, buffer empty the next cycle.
REQ-036 SHALL cover: redirect_pc=0x80000002 -> no req; one entry ex=1, pc=0x80000002; req stays 0 until a redirect to 0x80000004.
REQ-037 SHALL cover: with IF_BUF_BYPASS_EN, buffer empty and data_ok with ds_allowin=1 -> fs_to_ds_valid=1 the same cycle; without it, valid=1 the next cycle.
